// File: rtl/fitbit_pkg.sv
// rtl/fitbit_pkg.sv - shared constants and state encoding for the FitBit timebase
// Every timebase user imports this so they agree on the board clock rate.
package fitbit_pkg;

  localparam int DEFAULT_CLK_HZ   = 100_000_000;
  localparam int DEFAULT_WINDOW_S = 60;
  localparam int DEFAULT_SEC_W    = 14;

  typedef enum logic [1:0] {
    TB_IDLE   = 2'd0,
    TB_RUN    = 2'd1,
    TB_PAUSED = 2'd2
  } tb_state_t;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/half_sec_prescaler.sv
// rtl/half_sec_prescaler.sv - half-second prescaler with terminal-count pulse and phase bit
// The residue is only touched by en/zero, so pausing (en low) preserves it exactly.
module half_sec_prescaler
  import fitbit_pkg::*;
#(
  parameter int CLK_HZ = DEFAULT_CLK_HZ
) (
  input  logic fastclk,
  input  logic reset,
  input  logic en,
  input  logic zero,
  output logic tc,
  output logic phase
);

  localparam int HALF = CLK_HZ / 2;
  localparam int CW   = count_width(HALF);

  logic [CW-1:0] cnt;

  // tc is qualified by en so a blocked boundary cycle produces nothing.
  assign tc = en && (cnt == CW'(HALF - 1));

  always_ff @(posedge fastclk) begin
    if (reset || zero) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (en) begin
      if (tc) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/timebase_ctrl.sv
// rtl/timebase_ctrl.sv - run/pause/clear control, 2 Hz / 1 Hz strobes, window and elapsed-seconds tracking
// All outputs are registered; commands take effect on the edge that samples them.
module timebase_ctrl
  import fitbit_pkg::*;
#(
  parameter int CLK_HZ   = DEFAULT_CLK_HZ,
  parameter int WINDOW_S = DEFAULT_WINDOW_S,
  parameter int SEC_W    = DEFAULT_SEC_W
) (
  input  logic             fastclk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  output logic             tick_2hz,
  output logic             tick_1hz,
  output logic             blink,
  output logic             window_done,
  output logic [SEC_W-1:0] elapsed_s,
  output logic             running
);

  localparam int WIN_W = count_width(WINDOW_S);

  tb_state_t        state;
  tb_state_t        next_state;
  logic [WIN_W-1:0] win_cnt;
  logic             adv;
  logic             zero;
  logic             tc;
  logic             phase;
  logic             win_last;

  // pause outranks start even where pause itself has no effect (IDLE, PAUSED).
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = TB_IDLE;
    end else begin
      case (state)
        TB_IDLE:   if (start && !pause) next_state = TB_RUN;
        TB_RUN:    if (pause)           next_state = TB_PAUSED;
        TB_PAUSED: if (start && !pause) next_state = TB_RUN;
        default:                        next_state = TB_IDLE;
      endcase
    end
  end

  // The resume edge itself counts, so a pause of P cycles shifts strobes by exactly P.
  assign adv = !clear && !pause &&
               ((state == TB_RUN) || ((state == TB_PAUSED) && start));
  assign zero = clear || (state == TB_IDLE);
  assign win_last = (win_cnt == WIN_W'(WINDOW_S - 1));

  half_sec_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .fastclk(fastclk),
    .reset  (reset),
    .en     (adv),
    .zero   (zero),
    .tc     (tc),
    .phase  (phase)
  );

  always_ff @(posedge fastclk) begin
    if (reset) begin
      state       <= TB_IDLE;
      running     <= 1'b0;
      tick_2hz    <= 1'b0;
      tick_1hz    <= 1'b0;
      window_done <= 1'b0;
      blink       <= 1'b0;
      win_cnt     <= '0;
      elapsed_s   <= '0;
    end else begin
      state       <= next_state;
      running     <= (next_state == TB_RUN);
      tick_2hz    <= tc;
      tick_1hz    <= tc && phase;
      window_done <= tc && phase && win_last;

      if (zero) begin
        blink     <= 1'b0;
        win_cnt   <= '0;
        elapsed_s <= '0;
      end else if (tc) begin
        blink <= ~blink;
        if (phase) begin
          win_cnt <= win_last ? '0 : win_cnt + WIN_W'(1);
          if (elapsed_s != '1) begin
            elapsed_s <= elapsed_s + SEC_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_timebase_ctrl.sv
// tb/tb_timebase_ctrl.sv - directed bench for timebase_ctrl at CLK_HZ=8, WINDOW_S=3
module tb_timebase_ctrl;

  logic        fastclk;
  logic        reset;
  logic        start;
  logic        pause;
  logic        clear;

  logic        tick_2hz, tick_1hz, blink, window_done, running;
  logic [13:0] elapsed_s;

  logic        sat_tick_2hz, sat_tick_1hz, sat_blink, sat_window_done, sat_running;
  logic [1:0]  sat_elapsed_s;

  int total = 0;
  int bad   = 0;

  timebase_ctrl #(.CLK_HZ(8), .WINDOW_S(3), .SEC_W(14)) u_dut (
    .fastclk    (fastclk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .clear      (clear),
    .tick_2hz   (tick_2hz),
    .tick_1hz   (tick_1hz),
    .blink      (blink),
    .window_done(window_done),
    .elapsed_s  (elapsed_s),
    .running    (running)
  );

  timebase_ctrl #(.CLK_HZ(8), .WINDOW_S(3), .SEC_W(2)) u_dut_sat (
    .fastclk    (fastclk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .clear      (clear),
    .tick_2hz   (sat_tick_2hz),
    .tick_1hz   (sat_tick_1hz),
    .blink      (sat_blink),
    .window_done(sat_window_done),
    .elapsed_s  (sat_elapsed_s),
    .running    (sat_running)
  );

  initial fastclk = 1'b0;
  always #5 fastclk = ~fastclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge fastclk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".t2"}, tick_2hz, 0);
    check({tag, ".t1"}, tick_1hz, 0);
    check({tag, ".blink"}, blink, 0);
    check({tag, ".wd"}, window_done, 0);
    check({tag, ".elapsed"}, elapsed_s, 0);
    check({tag, ".running"}, running, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_idle("reset");
    check("reset.sat_elapsed", sat_elapsed_s, 0);

    // Free run from edge 0 for 48 edges, both instances.
    start = 1'b1;
    step();
    start = 1'b0;
    check("run.running0", running, 1);
    check("run.t2_0", tick_2hz, 0);
    for (int e = 1; e <= 48; e++) begin
      step();
      check($sformatf("run.t2@%0d", e), tick_2hz, (e % 4) == 0);
      check($sformatf("run.t1@%0d", e), tick_1hz, (e % 8) == 0);
      check($sformatf("run.wd@%0d", e), window_done, (e % 24) == 0);
      check($sformatf("run.elapsed@%0d", e), elapsed_s, e / 8);
      check($sformatf("run.blink@%0d", e), blink, (e / 4) % 2);
      check($sformatf("sat.elapsed@%0d", e), sat_elapsed_s, (e / 8 > 3) ? 3 : e / 8);
      check($sformatf("sat.t1@%0d", e), sat_tick_1hz, (e % 8) == 0);
    end

    // Pause at edge 6, resume at edge 16: first 1 Hz strobe lands after edge 18.
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_idle("clr1");
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      int r;
      logic a;
      pause = (e == 6);
      start = (e == 16);
      step();
      pause = 1'b0;
      start = 1'b0;
      r = (e <= 5) ? e : (e <= 15) ? 5 : e - 10;
      a = (e <= 5) || (e >= 16);
      check($sformatf("pz.t2@%0d", e), tick_2hz, a && (r % 4) == 0);
      check($sformatf("pz.t1@%0d", e), tick_1hz, a && (r % 8) == 0);
      check($sformatf("pz.elapsed@%0d", e), elapsed_s, r / 8);
      check($sformatf("pz.blink@%0d", e), blink, (r / 4) % 2);
      check($sformatf("pz.running@%0d", e), running, (e < 6) || (e >= 16));
    end

    // Clear in the terminal-count cycle of the second 1 Hz boundary.
    clear = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 15; e++) step();
    check("tc_clr.pre_elapsed", elapsed_s, 1);
    check("tc_clr.pre_blink", blink, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_idle("tc_clr");
    for (int e = 17; e <= 24; e++) begin
      step();
      check($sformatf("tc_clr.t2@%0d", e), tick_2hz, 0);
    end

    // pause+start in IDLE stays IDLE; clear+pause in RUN returns to IDLE.
    pause = 1'b1;
    start = 1'b1;
    step();
    pause = 1'b0;
    start = 1'b0;
    check("idle_ps.running", running, 0);
    for (int e = 0; e < 8; e++) begin
      step();
      check($sformatf("idle_ps.t2@%0d", e), tick_2hz, 0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 10; e++) step();
    check("cp.pre_running", running, 1);
    check("cp.pre_elapsed", elapsed_s, 1);
    clear = 1'b1;
    pause = 1'b1;
    step();
    clear = 1'b0;
    pause = 1'b0;
    check_idle("cp");

    // Pause exactly on the first half-second boundary, resume one cycle later.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 3; e++) step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    check("bnd.t2_pause", tick_2hz, 0);
    check("bnd.running_pause", running, 0);
    check("bnd.blink_pause", blink, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("bnd.t2_resume", tick_2hz, 1);
    check("bnd.blink_resume", blink, 1);
    check("bnd.running_resume", running, 1);
    step();
    check("bnd.t2_after", tick_2hz, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
